// File: rtl/score_bcd_counter.sv
// BCD score counter for a pipe game: scores one point per pipe crossing DETECT_COL,
// tracks the best score across games and freezes the score when the game ends.
module score_bcd_counter #(
  parameter int NUM_DIGITS = 2,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DETECT_COL = 6,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [ROWS-1:0][COLS-1:0]      green_array,
  input  logic                           clear,
  input  logic                           game_over,
  output logic [4*NUM_DIGITS-1:0]        score,
  output logic [4*NUM_DIGITS-1:0]        high_score,
  output logic                           point,
  output logic                           overflow,
  output logic                           new_high,
  output logic                           frozen
);

  typedef enum logic {RUN, FROZEN} state_t;

  state_t                    state;
  state_t                    next_state;
  logic                      occ;
  logic                      prev_occ;
  logic                      pass;
  logic                      carry;
  logic                      at_max;
  logic [4*NUM_DIGITS-1:0]   score_inc;

  always_comb begin
    occ = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      occ = occ | green_array[r][DETECT_COL];
    end
  end

  assign pass   = (state == RUN) && enable && occ && !prev_occ;
  assign frozen = (state == FROZEN);

  // Ripple the +1 through the digits; a carry out of the top digit means all nines.
  always_comb begin
    carry     = 1'b1;
    score_inc = score;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (carry) begin
        if (score[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score[4*d +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    at_max = carry;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = RUN;
    end else if ((state == RUN) && game_over) begin
      next_state = FROZEN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Priority: clear, then game_over, then a pass event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score      <= '0;
      high_score <= '0;
      prev_occ   <= 1'b0;
      point      <= 1'b0;
      overflow   <= 1'b0;
      new_high   <= 1'b0;
    end else begin
      point    <= 1'b0;
      overflow <= 1'b0;
      if (enable) begin
        prev_occ <= occ;
      end
      if (clear) begin
        score    <= '0;
        new_high <= 1'b0;
        prev_occ <= occ;
      end else if ((state == RUN) && game_over) begin
        if (score > high_score) begin
          high_score <= score;
          new_high   <= 1'b1;
        end
      end else if (pass) begin
        point <= 1'b1;
        if (!at_max) begin
          score <= score_inc;
        end else if (!SATURATE) begin
          score    <= '0;
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
